// File: rtl/alu_pkg.sv
// Shared opcodes, error constant and scheduler state encoding for the accelerator scheduler.
package alu_pkg;

  localparam int unsigned DataWidth = 19;

  localparam logic [4:0]           OP_FFT     = 5'd24;
  localparam logic [4:0]           OP_ENC     = 5'd25;
  localparam logic [4:0]           OP_DEC     = 5'd26;
  localparam logic [DataWidth-1:0] ERR_RESULT = 19'h7FFFF;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StFftWait = 2'd1,
    StCryWait = 2'd2,
    StResp    = 2'd3
  } sched_state_e;

  function automatic logic is_crypto_op(logic [4:0] op);
    return (op == OP_ENC) || (op == OP_DEC);
  endfunction

endpackage

// File: rtl/accel_timeout_timer.sv
// Wait-cycle counter for the scheduler; expired flags the last permitted wait cycle.
module accel_timeout_timer #(
  parameter int unsigned Limit = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [15:0] LastCount = 16'(Limit - 1);

  logic [15:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = enable && (count_q == LastCount);

endmodule

// File: rtl/accel_scheduler.sv
// Dispatches FFT/crypto commands to the accelerators and returns one response per command.
// Optional wait timeout is enabled by defining ACCEL_TIMEOUT_EN.
module accel_scheduler
  import alu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 issue_valid,
  output logic                 issue_ready,
  input  logic [4:0]           issue_opcode,
  input  logic [DataWidth-1:0] issue_operand_a,
  input  logic [DataWidth-1:0] issue_operand_b,
  output logic [DataWidth-1:0] accel_operand_a,
  output logic [DataWidth-1:0] accel_operand_b,
  output logic                 fft_start,
  input  logic                 fft_done,
  input  logic [DataWidth-1:0] fft_result,
  output logic                 crypto_start,
  output logic                 crypto_mode,
  input  logic                 crypto_done,
  input  logic [DataWidth-1:0] crypto_result,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [DataWidth-1:0] resp_result,
  output logic                 resp_err,
  output logic                 resp_zero,
  output logic                 stall
);

  sched_state_e         state_q, state_d;
  logic [DataWidth-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
  logic [DataWidth-1:0] result_q, result_d;
  logic                 err_q, err_d, zero_q, zero_d;
  logic                 mode_q, mode_d;
  logic                 fft_start_q, fft_start_d, crypto_start_q, crypto_start_d;
  logic                 accept, in_wait, timeout;

  assign accept  = issue_valid && (state_q == StIdle);
  assign in_wait = (state_q == StFftWait) || (state_q == StCryWait);

`ifdef ACCEL_TIMEOUT_EN
  accel_timeout_timer #(
    .Limit (TIMEOUT_CYCLES)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (accept),
    .enable  (in_wait),
    .expired (timeout)
  );
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d        = state_q;
    op_a_d         = op_a_q;
    op_b_d         = op_b_q;
    mode_d         = mode_q;
    result_d       = result_q;
    err_d          = err_q;
    zero_d         = zero_q;
    fft_start_d    = 1'b0;
    crypto_start_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          op_a_d = issue_operand_a;
          op_b_d = issue_operand_b;
          mode_d = issue_opcode[1];
          if (issue_opcode == OP_FFT) begin
            state_d     = StFftWait;
            fft_start_d = 1'b1;
          end else if (is_crypto_op(issue_opcode)) begin
            state_d        = StCryWait;
            crypto_start_d = 1'b1;
          end else begin
            state_d  = StResp;
            result_d = ERR_RESULT;
            err_d    = 1'b1;
            zero_d   = 1'b0;
          end
        end
      end
      StFftWait: begin
        // A done in the expiry cycle takes priority over the timeout.
        if (fft_done) begin
          state_d  = StResp;
          result_d = fft_result;
          err_d    = 1'b0;
          zero_d   = (fft_result == '0);
        end else if (timeout) begin
          state_d  = StResp;
          result_d = ERR_RESULT;
          err_d    = 1'b1;
          zero_d   = 1'b0;
        end
      end
      StCryWait: begin
        if (crypto_done) begin
          state_d  = StResp;
          result_d = crypto_result;
          err_d    = 1'b0;
          zero_d   = (crypto_result == '0);
        end else if (timeout) begin
          state_d  = StResp;
          result_d = ERR_RESULT;
          err_d    = 1'b1;
          zero_d   = 1'b0;
        end
      end
      StResp: begin
        if (resp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= StIdle;
      op_a_q         <= '0;
      op_b_q         <= '0;
      mode_q         <= 1'b0;
      result_q       <= '0;
      err_q          <= 1'b0;
      zero_q         <= 1'b0;
      fft_start_q    <= 1'b0;
      crypto_start_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      op_a_q         <= op_a_d;
      op_b_q         <= op_b_d;
      mode_q         <= mode_d;
      result_q       <= result_d;
      err_q          <= err_d;
      zero_q         <= zero_d;
      fft_start_q    <= fft_start_d;
      crypto_start_q <= crypto_start_d;
    end
  end

  assign issue_ready     = (state_q == StIdle);
  assign stall           = (state_q != StIdle);
  assign resp_valid      = (state_q == StResp);
  assign accel_operand_a = op_a_q;
  assign accel_operand_b = op_b_q;
  assign crypto_mode     = mode_q;
  assign fft_start       = fft_start_q;
  assign crypto_start    = crypto_start_q;
  assign resp_result     = result_q;
  assign resp_err        = err_q;
  // Zero flag is captured with the payload so it reads 0 out of reset.
  assign resp_zero       = zero_q;

endmodule

// File: tb/tb_accel_scheduler.sv
// Directed bench for accel_scheduler; timeout cases run when ACCEL_TIMEOUT_EN is defined.
module tb_accel_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        issue_valid = 1'b0;
  logic        issue_ready;
  logic [4:0]  issue_opcode = '0;
  logic [18:0] issue_operand_a = '0;
  logic [18:0] issue_operand_b = '0;
  logic [18:0] accel_operand_a, accel_operand_b;
  logic        fft_start, crypto_start, crypto_mode;
  logic        fft_done = 1'b0;
  logic [18:0] fft_result = '0;
  logic        crypto_done = 1'b0;
  logic [18:0] crypto_result = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [18:0] resp_result;
  logic        resp_err, resp_zero, stall;

  int n_checks = 0;
  int n_errors = 0;
  int fft_pulses = 0;

  accel_scheduler #(
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .issue_valid     (issue_valid),
    .issue_ready     (issue_ready),
    .issue_opcode    (issue_opcode),
    .issue_operand_a (issue_operand_a),
    .issue_operand_b (issue_operand_b),
    .accel_operand_a (accel_operand_a),
    .accel_operand_b (accel_operand_b),
    .fft_start       (fft_start),
    .fft_done        (fft_done),
    .fft_result      (fft_result),
    .crypto_start    (crypto_start),
    .crypto_mode     (crypto_mode),
    .crypto_done     (crypto_done),
    .crypto_result   (crypto_result),
    .resp_valid      (resp_valid),
    .resp_ready      (resp_ready),
    .resp_result     (resp_result),
    .resp_err        (resp_err),
    .resp_zero       (resp_zero),
    .stall           (stall)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (fft_start) fft_pulses++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] op, input logic [18:0] a, input logic [18:0] b);
    issue_valid     = 1'b1;
    issue_opcode    = op;
    issue_operand_a = a;
    issue_operand_b = b;
    tick();
    issue_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    // Reset state
    #2;
    check("rst_issue_ready", 32'(issue_ready), 32'd1);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_zero", 32'(resp_zero), 32'd0);
    check("rst_starts", 32'({fft_start, crypto_start, crypto_mode}), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // FFT path, done three cycles after the start pulse
    fft_pulses = 0;
    issue(5'd24, 19'h00123, 19'h00055);
    check("fft_start_pulse", 32'(fft_start), 32'd1);
    check("fft_op_a", 32'(accel_operand_a), 32'h00123);
    check("fft_op_b", 32'(accel_operand_b), 32'h00055);
    check("fft_stall", 32'({stall, issue_ready}), 32'b10);
    tick();
    check("fft_start_low", 32'(fft_start), 32'd0);
    check("fft_wait_no_resp", 32'(resp_valid), 32'd0);
    tick();
    tick();
    fft_done   = 1'b1;
    fft_result = 19'h0ABCD;
    tick();
    fft_done = 1'b0;
    check("fft_resp_valid", 32'(resp_valid), 32'd1);
    check("fft_resp_result", 32'(resp_result), 32'h0ABCD);
    check("fft_resp_flags", 32'({resp_err, resp_zero}), 32'b00);
    check("fft_pulse_count", 32'(fft_pulses), 32'd1);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    check("fft_back_idle", 32'({issue_ready, resp_valid}), 32'b10);

    // Decrypt path with zero result and backpressure
    crypto_result = 19'h0;
    issue(5'd26, 19'h00007, 19'h00009);
    check("dec_start", 32'(crypto_start), 32'd1);
    check("dec_mode", 32'(crypto_mode), 32'd1);
    tick();
    crypto_done = 1'b1;
    tick();
    crypto_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("dec_hold_valid", 32'({resp_valid, resp_zero, resp_err}), 32'b110);
      check("dec_hold_result", 32'(resp_result), 32'd0);
      tick();
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    check("dec_back_idle", 32'({issue_ready, resp_valid}), 32'b10);

    // Illegal opcode
    issue(5'd3, 19'h00001, 19'h00002);
    check("ill_no_start", 32'({fft_start, crypto_start}), 32'd0);
    check("ill_resp_valid", 32'(resp_valid), 32'd1);
    check("ill_resp_result", 32'(resp_result), 32'h7FFFF);
    check("ill_resp_flags", 32'({resp_err, resp_zero}), 32'b10);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;

    // Done while idle is ignored
    fft_done = 1'b1;
    tick();
    fft_done = 1'b0;
    check("idle_done_ignored", 32'({issue_ready, resp_valid}), 32'b10);

    // Cross done ignored in CRY_WAIT, then crypto_done accepted
    issue(5'd25, 19'h00011, 19'h00022);
    check("enc_mode", 32'({crypto_start, crypto_mode}), 32'b10);
    fft_done   = 1'b1;
    fft_result = 19'h05555;
    tick();
    fft_done = 1'b0;
    check("cross_ignored", 32'({resp_valid, stall}), 32'b01);
    crypto_done   = 1'b1;
    crypto_result = 19'h11111;
    tick();
    crypto_done = 1'b0;
    check("cross_resp_result", 32'(resp_result), 32'h11111);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;

    // Done in the start-pulse cycle counts
    issue(5'd25, 19'h00001, 19'h00001);
    crypto_done   = 1'b1;
    crypto_result = 19'h00777;
    tick();
    crypto_done = 1'b0;
    check("imm_resp_valid", 32'(resp_valid), 32'd1);
    check("imm_resp_result", 32'(resp_result), 32'h00777);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;

    // Reset during FFT_WAIT abandons the command
    issue(5'd24, 19'h00abc, 19'h00def);
    tick();
    rst = 1'b1;
    #1;
    check("midrst_ready", 32'({issue_ready, stall, resp_valid}), 32'b100);
    check("midrst_operand", 32'(accel_operand_a), 32'd0);
    check("midrst_pulses", 32'({fft_start, crypto_start, crypto_mode}), 32'd0);
    tick();
    rst = 1'b0;
    fft_done   = 1'b1;
    fft_result = 19'h00001;
    tick();
    fft_done = 1'b0;
    check("late_done_ignored", 32'({issue_ready, resp_valid}), 32'b10);

`ifdef ACCEL_TIMEOUT_EN
    // Timeout after 8 wait cycles with no done
    issue(5'd24, 19'h00001, 19'h00001);
    for (int i = 0; i < 7; i++) tick();
    check("to_still_wait", 32'(resp_valid), 32'd0);
    tick();
    check("to_resp_valid", 32'(resp_valid), 32'd1);
    check("to_resp_err", 32'({resp_err, resp_zero}), 32'b10);
    check("to_resp_result", 32'(resp_result), 32'h7FFFF);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;

    // Done in the expiry cycle wins
    issue(5'd24, 19'h00001, 19'h00001);
    for (int i = 0; i < 7; i++) tick();
    fft_done   = 1'b1;
    fft_result = 19'h00042;
    tick();
    fft_done = 1'b0;
    check("to_done_wins_err", 32'(resp_err), 32'd0);
    check("to_done_wins_result", 32'(resp_result), 32'h00042);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
